// File: rtl/stdp_update_controller.sv
// stdp_update_controller: detects pre/post spike pairings inside a decaying window and issues
// LTP/LTD weight commands over valid/ready, keeping a saturating committed weight.
module stdp_update_controller #(
  parameter int WEIGHT_W    = 8,
  parameter int WINDOW_LOG2 = 4,
  parameter int A_PLUS      = 4,
  parameter int A_MINUS     = 3,
  parameter int W_INIT      = 64,
  parameter int W_MIN       = 0,
  parameter int W_MAX       = 255,
  parameter int COOLDOWN    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                learn_en,
  input  logic                pre_spike,
  input  logic                post_spike,
  output logic                cmd_valid,
  input  logic                cmd_ready,
  output logic                cmd_ltp,
  output logic [WEIGHT_W-1:0] cmd_mag,
  output logic [WEIGHT_W-1:0] weight,
  output logic                busy,
  output logic [7:0]          drop_count
);
  typedef enum logic [1:0] {IDLE, ISSUE, COOL} state_t;
  localparam logic [WINDOW_LOG2:0] T_LOAD = {1'b1, {WINDOW_LOG2{1'b0}}};
  localparam logic [WINDOW_LOG2:0] T_ONE  = {{WINDOW_LOG2{1'b0}}, 1'b1};
  state_t                r_state, w_state_n;
  logic                  r_pre_d, r_post_d;
  logic [WINDOW_LOG2:0]  r_pre_t, r_post_t;
  logic                  r_pend_v, r_pend_ltp, r_cmd_ltp;
  logic [WEIGHT_W-1:0]   r_pend_mag, r_cmd_mag, r_weight;
  logic [7:0]            r_drop, r_cd;
  logic                  w_pre_e, w_post_e, w_ltp_ev, w_ltd_ev, w_ev, w_idle, w_accept;
  logic [31:0]           w_pp;
  logic [WEIGHT_W-1:0]   w_mag, w_w_upd;
  logic [WEIGHT_W:0]     w_sum, w_dif;
  always_comb begin
    w_pre_e  = pre_spike & ~r_pre_d;
    w_post_e = post_spike & ~r_post_d;
    w_ltp_ev = learn_en & w_post_e & ~w_pre_e & (r_pre_t != '0);
    w_ltd_ev = learn_en & w_pre_e & ~w_post_e & (r_post_t != '0);
    w_ev     = w_ltp_ev | w_ltd_ev;
    w_pp     = (w_ltp_ev ? 32'(A_PLUS) : 32'(A_MINUS)) * 32'(w_ltp_ev ? r_pre_t : r_post_t) >> WINDOW_LOG2;
    w_mag    = (w_pp == 32'd0) ? WEIGHT_W'(1) : w_pp[WEIGHT_W-1:0];
    w_idle   = r_state == IDLE;
    w_accept = r_state == ISSUE & cmd_ready;
    // one extra bit so saturation is decided before any wrap
    w_sum    = {1'b0, r_weight} + {1'b0, r_cmd_mag};
    w_dif    = {1'b0, r_weight} - {1'b0, r_cmd_mag};
    w_w_upd  = r_cmd_ltp
      ? ((w_sum > (WEIGHT_W+1)'(W_MAX)) ? WEIGHT_W'(W_MAX) : w_sum[WEIGHT_W-1:0])
      : ((w_dif[WEIGHT_W] | (w_dif < (WEIGHT_W+1)'(W_MIN))) ? WEIGHT_W'(W_MIN) : w_dif[WEIGHT_W-1:0]);
  end
  always_comb begin
    w_state_n = r_state;
    if (w_idle & (r_pend_v | w_ev)) w_state_n = ISSUE;
    else if (w_accept) w_state_n = COOL;
    else if (r_state == COOL && r_cd == 8'd0) w_state_n = IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_state_n;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre_d    <= 1'b0;
      r_post_d   <= 1'b0;
      r_pre_t    <= '0;
      r_post_t   <= '0;
      r_pend_v   <= 1'b0;
      r_pend_ltp <= 1'b0;
      r_pend_mag <= '0;
      r_cmd_ltp  <= 1'b0;
      r_cmd_mag  <= '0;
      r_weight   <= WEIGHT_W'(W_INIT);
      r_drop     <= 8'd0;
      r_cd       <= 8'd0;
    end else begin
      r_pre_d  <= pre_spike;
      r_post_d <= post_spike;
      r_pre_t  <= w_pre_e ? T_LOAD : w_ltp_ev ? '0 : (r_pre_t == '0) ? '0 : r_pre_t - T_ONE;
      r_post_t <= w_post_e ? T_LOAD : w_ltd_ev ? '0 : (r_post_t == '0) ? '0 : r_post_t - T_ONE;
      if (w_idle & r_pend_v) begin
        r_cmd_ltp <= r_pend_ltp;
        r_cmd_mag <= r_pend_mag;
        r_pend_v  <= 1'b0;
      end else if (w_idle & w_ev) begin
        r_cmd_ltp <= w_ltp_ev;
        r_cmd_mag <= w_mag;
      end else if (w_ev & ~r_pend_v) begin
        r_pend_v   <= 1'b1;
        r_pend_ltp <= w_ltp_ev;
        r_pend_mag <= w_mag;
      end
      if (w_ev & r_pend_v & (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
      if (w_accept) r_weight <= w_w_upd;
      r_cd <= w_accept ? 8'(COOLDOWN - 1) : (r_state == COOL && r_cd != 8'd0) ? r_cd - 8'd1 : r_cd;
    end
  end
  assign cmd_valid  = r_state == ISSUE;
  assign cmd_ltp    = r_cmd_ltp;
  assign cmd_mag    = r_cmd_mag;
  assign weight     = r_weight;
  assign busy       = (r_state != IDLE) | r_pend_v;
  assign drop_count = r_drop;
endmodule
